// File: rtl/floor_div_seq_16.sv
// Multi-cycle restoring floor divider producing one quotient bit per clock,
// with valid/ready on both sides. Signed floor mode is enabled by FLOORDIV_SIGNED_EN.
module floor_div_seq_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

`ifdef FLOORDIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dsr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   step_quo, step_rem;
  logic [WIDTH-1:0]   res_q, res_r;
  logic               last_step;
  logic               ld_out;

`ifdef FLOORDIV_SIGNED_EN
  logic [WIDTH-1:0]   a_raw_q;
  logic               neg_a_q, neg_b_q;

  assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  assign in_ready  = (state_q == IDLE);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // One restoring step: the full WIDTH+1-bit partial remainder is compared,
  // and since it is below 2*divisor the difference always fits in WIDTH bits.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, dsr_q});
    step_rem = ge ? (shifted[WIDTH-1:0] - dsr_q) : shifted[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], ge};
  end

  // Result presented to the output registers when entering DONE.
  always_comb begin
`ifdef FLOORDIV_SIGNED_EN
    res_q = dvd_q;
    res_r = rem_q;
    if (neg_a_q ^ neg_b_q) begin
      res_q = ~dvd_q + WIDTH'(1);
      if (rem_q != '0) begin
        res_q = res_q - WIDTH'(1);
        res_r = dsr_q - rem_q;
      end
    end
    if (neg_b_q) begin
      res_r = ~res_r + WIDTH'(1);
    end
    if (dbz_q) begin
      res_q = '1;
      res_r = a_raw_q;
    end
`else
    res_q = step_quo;
    res_r = step_rem;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_out  = 1'b0;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: begin
        if (last_step) begin
`ifdef FLOORDIV_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
          ld_out  = 1'b1;
`endif
        end
      end
`ifdef FLOORDIV_SIGNED_EN
      FIX: begin
        state_d = DONE;
        ld_out  = 1'b1;
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Iteration datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
`ifdef FLOORDIV_SIGNED_EN
      a_raw_q     <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
`endif
    end else begin
      out_valid <= (state_d == DONE);
      if (state_q == IDLE && in_valid) begin
        dvd_q <= a_mag;
        dsr_q <= b_mag;
        rem_q <= '0;
        cnt_q <= '0;
        dbz_q <= (b == '0);
`ifdef FLOORDIV_SIGNED_EN
        a_raw_q <= a;
        neg_a_q <= a[WIDTH-1];
        neg_b_q <= b[WIDTH-1];
`endif
      end else if (state_q == CALC) begin
        dvd_q <= step_quo;
        rem_q <= step_rem;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (ld_out) begin
        quotient    <= res_q;
        remainder   <= res_r;
        div_by_zero <= dbz_q;
      end
    end
  end

endmodule

// File: tb/tb_floor_div_seq_16.sv
// Self-checking bench for floor_div_seq_16: directed vector table, stall,
// mid-operation reset and a randomised back-to-back scoreboard run.
module tb_floor_div_seq_16;

`ifdef FLOORDIV_SIGNED_EN
  localparam int LAT = 17;
  localparam logic [15:0] RMASK = 16'h7FFF;
`else
  localparam int LAT = 16;
  localparam logic [15:0] RMASK = 16'hFFFF;
`endif
  localparam int NV = 8;
  localparam int NR = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient, remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs [NV];

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];

  floor_div_seq_16 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE with out_ready=1 and check latency and result.
  task automatic run_op(input string nm, input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] eq, input logic [15:0] er, input logic edbz);
    int n;
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({nm, "_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(LAT));
    check({nm, "_q"}, 32'(quotient), 32'(eq));
    check({nm, "_r"}, 32'(remainder), 32'(er));
    check({nm, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    tick();
    check({nm, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({nm, "_idle"}, 32'(in_ready), 32'd1);
    check({nm, "_q_hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    logic [15:0] sq, sr, hq, hr;
    int n;
    bit done_drv;
    int got;

`ifdef FLOORDIV_SIGNED_EN
    vecs[0] = '{16'hFFF9, 16'd2,    16'hFFFC, 16'd1,    1'b0};
    vecs[1] = '{16'd7,    16'hFFFE, 16'hFFFC, 16'hFFFF, 1'b0};
    vecs[2] = '{16'hFFF8, 16'hFFFE, 16'd4,    16'd0,    1'b0};
    vecs[3] = '{16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0};
    vecs[4] = '{16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1};
    vecs[5] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
    vecs[6] = '{16'hFFFA, 16'd3,    16'hFFFE, 16'd0,    1'b0};
    vecs[7] = '{16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0};
    hq = 16'hFFFF; hr = 16'd254;
`else
    vecs[0] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
    vecs[1] = '{16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1};
    vecs[2] = '{16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0};
    vecs[3] = '{16'd9,    16'd3,    16'd3,    16'd0,    1'b0};
    vecs[4] = '{16'd0,    16'd5,    16'd0,    16'd0,    1'b0};
    vecs[5] = '{16'd5,    16'd9,    16'd0,    16'd5,    1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0};
    vecs[7] = '{16'h8000, 16'h7FFF, 16'd1,    16'd1,    1'b0};
    hq = 16'd257; hr = 16'd0;
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
    end

    // Output stall: result held for 20 cycles, stray in_valid ignored.
    out_ready = 1'b0;
    a = 16'hFFFF; b = 16'd255; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("stall_latency", 32'(n), 32'(LAT));
    check("stall_q", 32'(quotient), 32'(hq));
    check("stall_r", 32'(remainder), 32'(hr));
    sq = quotient; sr = remainder;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        a = 16'd3; b = 16'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("stall_ov", 32'(out_valid), 32'd1);
      check("stall_q_stable", 32'({quotient, remainder}), 32'({hq, hr}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release_ov", 32'(out_valid), 32'd0);
    check("stall_release_idle", 32'(in_ready), 32'd1);
    tick();
    check("stall_single_hs", 32'(out_valid), 32'd0);
    check("stall_still_idle", 32'(in_ready), 32'd1);
    check("stall_data_kept", 32'({quotient, remainder}), 32'({sq, sr}));

    // Asynchronous reset in the middle of a computation.
    a = 16'd500; b = 16'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("mid_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_ov", 32'(out_valid), 32'd0);
    check("arst_q", 32'(quotient), 32'd0);
    check("arst_r", 32'(remainder), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    check("arst_idle", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    tick();
    n = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) n++;
      tick();
    end
    check("arst_no_result", 32'(n), 32'd0);
    run_op("post_rst", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

    // Back-to-back random run against a reference model.
    done_drv = 1'b0;
    got = 0;
    fork
      begin
        for (int i = 0; i < NR; i++) begin
          logic rdy;
          int w;
          logic [15:0] ra, rb;
          repeat ($urandom_range(0, 3)) tick();
          ra = 16'($urandom) & RMASK;
          rb = 16'($urandom_range(1, 16'hFFFF)) & RMASK;
          if (rb == '0) rb = 16'd1;
          if (i % 4 == 0) rb = 16'($urandom_range(1, 40));
          a = ra; b = rb; in_valid = 1'b1;
          w = 0;
          do begin
            rdy = in_ready;
            tick();
            w++;
          end while (!rdy && w < 200);
          in_valid = 1'b0;
          if (!rdy) check("drv_accept_timeout", 32'd0, 32'd1);
          else sb.push_back('{ra / rb, ra % rb});
        end
        done_drv = 1'b1;
      end
      begin
        int cyc;
        exp_t e;
        cyc = 0;
        while (got < NR && cyc < 5000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              check("rnd_unexpected", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check($sformatf("rnd%0d_q", got), 32'(quotient), 32'(e.q));
              check($sformatf("rnd%0d_r", got), 32'(remainder), 32'(e.r));
            end
            got++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    check("rnd_all_received", 32'(got), 32'(NR));
    check("rnd_driver_done", 32'(done_drv), 32'd1);
    check("rnd_sb_empty", 32'(sb.size()), 32'd0);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid) n++;
    end
    check("rnd_no_extra", 32'(n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
